ssd_scan_controller: RTL and testbench
======================================

Name: ssd_scan_controller

Overview:
- Parametrised multiplexed seven-segment driver for the Nexys4 board.
- Scans NUM_DIGITS common-anode digits at a prescaled rate.
- Adds hex decode, per-digit enable, blink, decimal points and leading-zero suppression.
- Double-buffers the display value and updates it only at frame boundaries, so there is no tearing.
- Sits beside the VGA datapath in the top level and takes score/debug nibbles from the game logic.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (1..8).
- PRESCALE_BITS, 18: scan tick every 2^PRESCALE_BITS clocks (~381 Hz per digit at 100 MHz).
- BLINK_BITS, 26: free-running blink counter width; blink phase = counter MSB.
- ACTIVE_LOW, 1: 1 = anodes/cathodes driven active-low; 0 = active-high.

Ports:
- ClkPort  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high reset
- en  in  1  1 = scanning; 0 = hold counters, all anodes off
- load  in  1  one-cycle strobe to capture digits/dp/digit_en/blink
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i], digit 0 rightmost
- dp  in  NUM_DIGITS  decimal point per digit
- digit_en  in  NUM_DIGITS  per-digit enable
- blink  in  NUM_DIGITS  per-digit blink enable
- lz_blank  in  1  leading-zero suppression enable (live, not buffered)
- An  out  NUM_DIGITS  anode drives
- Ca  out  8  cathodes {dp,g,f,e,d,c,b,a}
- scan_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently being driven
- pending  out  1  buffered value waiting for a frame boundary
- frame_tick  out  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset (async): prescaler=0, blink counter=0, scan_idx=0, pending=0, frame_tick=0.
- Reset (async): pend and active registers = 0; An and Ca = all off (all 1s if ACTIVE_LOW).
- Prescaler: increments each clock while en=1 and holds while en=0.
- Scan tick: asserted the cycle the prescaler equals all-ones; prescaler then wraps to 0.
- On tick: scan_idx increments; NUM_DIGITS-1 wraps to 0.
- frame_tick: registered pulse in the cycle after a wrap to 0. Never asserted when NUM_DIGITS=1 except on each tick.
- Blink counter: free-runs regardless of en.
- Buffer:
  - load=1 captures the inputs into pend registers and sets pending=1.
  - A wrap tick with pending=1 copies pend to active and clears pending.
  - load on a non-wrap cycle overwrites pend; the last load before the boundary wins.
  - load coincident with a wrap tick writes the inputs to both pend and active; pending=0.
- Visibility of digit i requires all of:
  - digit_en[i]=1;
  - NOT (blink[i]=1 and blink MSB=1);
  - NOT leading-zero blanked.
- Leading-zero blanking: with lz_blank=1, digit i is blanked if it and every higher-index digit is 0. Digit 0 is never blanked by lz, so value 0 shows "0".
- Leading-zero scan runs over active nibbles only. A disabled digit with nonzero value still terminates suppression.
- Decode: standard hex 0-9, A, b, C, d, E, F. dp bit comes from active dp[scan_idx].
- Output register:
  - An/Ca are registered from scan_idx, giving one-cycle latency after a scan_idx change.
  - An = one-hot(scan_idx) if visible and en=1, else all off.
  - Ca = all off whenever the digit is not visible.
  - Polarity is inverted when ACTIVE_LOW=1.
- en falling: An forced off on the next edge. Scan resumes from the held scan_idx/prescaler. Pending transfer waits for the next wrap.
- Reset mid-frame: immediate return to reset state; any pending value is discarded.

Test Plan (NUM_DIGITS=4, PRESCALE_BITS=2, BLINK_BITS=4, ACTIVE_LOW=1):
- Reset, en=1, load digits=16'h12AF, digit_en=4'hF, no blink/lz:
  - pend holds until the first wrap, then An cycles 1110,1101,1011,0111;
  - each anode is held 4 clocks;
  - Ca = 8'hF9 ("1"), 8'hA4 ("2"), 8'h88 ("A"), 8'h8E ("F") in digit order 3..0, lagging scan_idx by 1 cycle;
  - frame_tick pulses every 16 clocks.
- load 16'h1234 mid-frame, then 16'h5678 two cycles later:
  - pending=1 until the wrap;
  - the display shows 5678 from the next frame; 1234 is never shown.
- load asserted exactly on the wrap tick with 16'h00C0 and lz_blank=1:
  - the new value is shown in the same frame; pending stays 0;
  - digit 3 An stays 1 and Ca=FF; digit 2 is also off;
  - digit 1 shows "C" (8'hC6); digit 0 shows "0" (8'hC0).
- blink=4'b0001, digit_en=4'hF: digit 0 is dark whenever blink MSB=1 (alternate 8-clock windows); digits 1-3 are unaffected.
- en deasserted mid-digit for 10 clocks: An=4'hF from the next edge; scan_idx and prescaler are frozen; on re-enable, scanning continues from the same digit.
- Reset asserted asynchronously mid-frame with pending=1: An=4'hF and Ca=8'hFF immediately; pending=0; scan_idx=0; the after-reset display shows 0000 (lz off) once active.

Source files
------------

// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan driver with hex decode, blink, decimal points,
// leading-zero suppression and a frame-synchronous double buffer.
module ssd_scan_controller #(
  parameter int NUM_DIGITS    = 8,
  parameter int PRESCALE_BITS = 18,
  parameter int BLINK_BITS    = 26,
  parameter bit ACTIVE_LOW    = 1'b1,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   An,
  output logic [7:0]              Ca,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            CA_OFF = {8{ACTIVE_LOW}};

  logic [PRESCALE_BITS-1:0] prescaler;
  logic [BLINK_BITS-1:0]    blink_cnt;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_en, act_en;
  logic [NUM_DIGITS-1:0]   pend_blink, act_blink;

  logic tick, last_digit, wrap;

  assign tick       = en && (&prescaler);
  assign last_digit = (scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = tick && last_digit;

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] lz_mask, vis;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_vis, cur_dp;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [7:0]            ca_raw;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    // Walk from the most significant digit down; the first nonzero nibble ends the run.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (act_digits[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_blank && zero_run && (i != 0);
    end
    vis     = act_en & ~(act_blink & {NUM_DIGITS{blink_cnt[BLINK_BITS-1]}}) & ~lz_mask;
    cur_nib = act_digits[{scan_idx, 2'b00} +: 4];
    cur_vis = vis[scan_idx];
    cur_dp  = act_dp[scan_idx];
    an_raw  = (en && cur_vis) ? (NUM_DIGITS'(1) << scan_idx) : '0;
    ca_raw  = cur_vis ? {cur_dp, hex_to_seg(cur_nib)} : 8'h00;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      prescaler   <= '0;
      blink_cnt   <= '0;
      scan_idx    <= '0;
      pending     <= 1'b0;
      frame_tick  <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_blink  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_blink   <= '0;
      An          <= AN_OFF;
      Ca          <= CA_OFF;
    end else begin
      blink_cnt  <= blink_cnt + BLINK_BITS'(1);
      frame_tick <= wrap;

      if (en) prescaler <= prescaler + PRESCALE_BITS'(1);
      if (tick) scan_idx <= last_digit ? '0 : scan_idx + IDX_W'(1);

      // A load on the wrap tick bypasses straight into the active copy.
      if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp;
        pend_en     <= digit_en;
        pend_blink  <= blink;
        if (wrap) begin
          act_digits <= digits;
          act_dp     <= dp;
          act_en     <= digit_en;
          act_blink  <= blink;
          pending    <= 1'b0;
        end else begin
          pending    <= 1'b1;
        end
      end else if (wrap && pending) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_en     <= pend_en;
        act_blink  <= pend_blink;
        pending    <= 1'b0;
      end

      An <= an_raw ^ AN_OFF;
      Ca <= ca_raw ^ CA_OFF;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: stimulus queues edge-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ssd_scan_controller;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        en, load, lz_blank;
  logic [15:0] digits;
  logic [3:0]  dp, digit_en, blink;
  logic [3:0]  An;
  logic [7:0]  Ca;
  logic [1:0]  scan_idx;
  logic        pending, frame_tick;

  ssd_scan_controller #(
    .NUM_DIGITS(4), .PRESCALE_BITS(2), .BLINK_BITS(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .ClkPort(ClkPort), .Reset(Reset), .en(en), .load(load), .digits(digits),
    .dp(dp), .digit_en(digit_en), .blink(blink), .lz_blank(lz_blank),
    .An(An), .Ca(Ca), .scan_idx(scan_idx), .pending(pending), .frame_tick(frame_tick)
  );

  typedef enum {K_AN, K_CA, K_IDX, K_PEND, K_FT} kind_t;
  typedef struct {
    int    at;
    kind_t kind;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  always #5 ClkPort = ~ClkPort;
  always @(posedge ClkPort) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sample(input kind_t k);
    case (k)
      K_AN:    return int'(An);
      K_CA:    return int'(Ca);
      K_IDX:   return int'(scan_idx);
      K_PEND:  return int'(pending);
      default: return int'(frame_tick);
    endcase
  endfunction

  task automatic expect_at(input int at, input kind_t k, input int v, input string n);
    exp_t e;
    e.at   = at;
    e.kind = k;
    e.val  = v;
    e.name = $sformatf("%s@%0d", n, at);
    sb.push_back(e);
  endtask

  task automatic expect_disp(input int at, input int an, input int ca, input string n);
    expect_at(at, K_AN, an, {n, "_an"});
    expect_at(at, K_CA, ca, {n, "_ca"});
  endtask

  // Monitor: at each falling edge, compare every expectation stamped with the current edge.
  always @(negedge ClkPort) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].at == edge_n) check(sb[i].name, sample(sb[i].kind), sb[i].val);
      else if (sb[i].at < edge_n) check({sb[i].name, "_missed"}, 0, 1);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic goto(input int k);
    while (edge_n < k) begin
      @(posedge ClkPort);
      #1;
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] de,
                            input logic [3:0] bl, input logic [3:0] p);
    digits   = d;
    digit_en = de;
    blink    = bl;
    dp       = p;
    load     = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int B  = 2;
  localparam int B2 = B + 136;

  initial begin
    Reset = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
    digits = '0; dp = '0; digit_en = '0; blink = '0;

    // Reset state
    expect_disp(1, 'hF, 'hFF, "rst");
    expect_at(1, K_IDX, 0, "rst_idx");
    expect_at(1, K_PEND, 0, "rst_pend");
    expect_at(1, K_FT, 0, "rst_ft");
    // Basic scan of 12AF, buffered until the first wrap
    expect_at(B+1,  K_PEND, 1, "p1_pend");
    expect_at(B+1,  K_AN, 'hF, "p1_dark");
    expect_at(B+4,  K_IDX, 1, "p1_idx");
    expect_at(B+15, K_PEND, 1, "p1_pend_hold");
    expect_at(B+15, K_IDX, 3, "p1_idx3");
    expect_at(B+16, K_PEND, 0, "p1_pend_clr");
    expect_at(B+16, K_FT, 1, "p1_ft");
    expect_at(B+16, K_IDX, 0, "p1_idx_wrap");
    expect_at(B+17, K_FT, 0, "p1_ft_end");
    expect_disp(B+17, 'hE, 'h8E, "p1_d0");
    expect_disp(B+20, 'hE, 'h8E, "p1_d0_hold");
    expect_disp(B+21, 'hD, 'h88, "p1_d1");
    expect_disp(B+25, 'hB, 'hA4, "p1_d2");
    expect_disp(B+29, 'h7, 'hF9, "p1_d3");
    expect_at(B+31, K_FT, 0, "p1_ft_gap");
    expect_at(B+32, K_FT, 1, "p1_ft2");
    // Two mid-frame loads: last wins, shown only after the wrap
    expect_at(B+37, K_PEND, 1, "p2_pend");
    expect_disp(B+37, 'hD, 'h88, "p2_old_d1");
    expect_disp(B+45, 'h7, 'hF9, "p2_old_d3");
    expect_at(B+47, K_PEND, 1, "p2_pend_hold");
    expect_at(B+48, K_PEND, 0, "p2_pend_clr");
    expect_disp(B+49, 'hE, 'h80, "p2_d0_8");
    expect_disp(B+53, 'hD, 'hF8, "p2_d1_7");
    expect_disp(B+57, 'hB, 'h82, "p2_d2_6");
    expect_disp(B+61, 'h7, 'h92, "p2_d3_5");
    // Load on the wrap tick with leading-zero suppression
    expect_at(B+64, K_PEND, 0, "p3_pend");
    expect_at(B+64, K_FT, 1, "p3_ft");
    expect_disp(B+65, 'hE, 'hC0, "p3_d0_zero");
    expect_disp(B+69, 'hD, 'hC6, "p3_d1_C");
    expect_disp(B+73, 'hF, 'hFF, "p3_d2_lz");
    expect_disp(B+77, 'hF, 'hFF, "p3_d3_lz");
    // Blink on digit 0, dp on digit 1
    expect_at(B+79, K_PEND, 1, "p4_pend");
    expect_at(B+80, K_PEND, 0, "p4_pend_clr");
    expect_disp(B+81, 'hE, 'h8E, "p4_d0_lit");
    expect_disp(B+85, 'hD, 'h08, "p4_d1_dp");
    expect_disp(B+93, 'h7, 'hF9, "p4_d3_noblink");
    // en pause for 10 clocks
    expect_at(B+99,  K_AN, 'hF, "p5_off");
    expect_at(B+108, K_AN, 'hF, "p5_off_end");
    expect_at(B+108, K_IDX, 0, "p5_idx_frozen");
    expect_at(B+109, K_IDX, 0, "p5_idx_resume");
    expect_at(B+110, K_IDX, 1, "p5_idx_next");
    expect_disp(B+111, 'hD, 'h08, "p5_d1");
    expect_at(B+122, K_FT, 1, "p5_ft");
    expect_disp(B+123, 'hF, 'hFF, "p5_d0_blink");
    expect_at(B+126, K_AN, 'hF, "p5_d0_blink_end");
    expect_disp(B+127, 'hD, 'h08, "p5_d1_unaffected");
    expect_disp(B+131, 'hB, 'hA4, "p5_d2");
    // Asynchronous reset mid-frame with a pending value
    expect_at(B+133, K_PEND, 1, "p6_pend");
    expect_disp(B+134, 'hF, 'hFF, "p6_async");
    expect_at(B+134, K_PEND, 0, "p6_pend_rst");
    expect_at(B+134, K_IDX, 0, "p6_idx_rst");
    expect_at(B2+1,  K_PEND, 1, "p6_reload");
    expect_at(B2+5,  K_AN, 'hF, "p6_act_cleared");
    expect_at(B2+16, K_PEND, 0, "p6_pend_clr");
    expect_at(B2+16, K_FT, 1, "p6_ft");
    expect_disp(B2+17, 'hE, 'hC0, "p6_d0");
    expect_disp(B2+29, 'h7, 'hC0, "p6_d3");

    goto(B);
    Reset = 1'b0;
    en    = 1'b1;
    drive_load(16'h12AF, 4'hF, 4'h0, 4'h0);
    goto(B+1);   load = 1'b0;

    goto(B+35);  drive_load(16'h1234, 4'hF, 4'h0, 4'h0);
    goto(B+36);  load = 1'b0;
    goto(B+37);  drive_load(16'h5678, 4'hF, 4'h0, 4'h0);
    goto(B+38);  load = 1'b0;

    goto(B+63);  drive_load(16'h00C0, 4'hF, 4'h0, 4'h0); lz_blank = 1'b1;
    goto(B+64);  load = 1'b0;

    goto(B+71);  drive_load(16'h12AF, 4'hF, 4'b0001, 4'b0010);
    goto(B+72);  load = 1'b0;
    goto(B+80);  lz_blank = 1'b0;

    goto(B+98);  en = 1'b0;
    goto(B+108); en = 1'b1;

    goto(B+131); drive_load(16'h4321, 4'hF, 4'h0, 4'h0);
    goto(B+132); load = 1'b0;
    goto(B+134); #2 Reset = 1'b1;
    goto(B2);
    Reset = 1'b0;
    drive_load(16'h0000, 4'hF, 4'h0, 4'h0);
    goto(B2+1);  load = 1'b0;

    goto(B2+31);
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
